sap1_control_sequencer: RTL and testbench
=========================================

Name: sap1_control_sequencer

Overview:
- Control sequencer for the SAP-1 datapath (PC, MAR, RAM, IR, A, B, ALU, OUT; all built from ci74173-style 4-bit registers).
- Runs a 6-state ring counter, T1..T6, and decodes the IR opcode nibble into the 12-bit control word.
- The control word drives the registers' active-low load enables and the tri-state bus enables.
- It also decodes the halt condition for the clock gate.

Parameters:
- none (fixed SAP-1 instruction set)

Ports:
- clk  input  1  system clock; datapath registers load on the rising edge
- n_rst  input  1  asynchronous, active-low reset
- opcode  input  4  IR upper nibble, valid from T4 onward
- ctrl  output  12  control word {Cp, Ep, n_Lm, n_CE, n_Li, n_Ei, n_La, Ea, Su, Eu, n_Lb, n_Lo}, MSB first
- t  output  6  one-hot ring state; t[0]=T1 ... t[5]=T6
- hlt  output  1  high when halted; the clock gate stops the system clock

Behaviour:
- Reset
  - n_rst low asynchronously forces t=6'b000001, hlt=0, ctrl=12'h3E3 (all inactive), and clears the arm flag.
  - Outputs hold these values while n_rst is low.
- Timing
  - The ring advances on the falling edge of clk, so ctrl is stable at each rising edge.
  - Arm flag: set on the first rising edge after reset release.
  - No ring advance occurs until the arm flag is set. This guarantees T1 is seen by at least one rising edge.
  - ctrl is purely combinational from (t, opcode, hlt). There are no extra pipeline stages.
- Ring order: T1->T2->T3->T4->T5->T6->T1, one state per falling edge.
- Fetch words (all opcodes):
  - T1 = 12'h5E3 (Ep, n_Lm=0)
  - T2 = 12'hBE3 (Cp)
  - T3 = 12'h263 (n_CE=0, n_Li=0)
- LDA 4'b0000:
  - T4 = 12'h1A3 (n_Lm=0, n_Ei=0)
  - T5 = 12'h2C3 (n_CE=0, n_La=0)
  - T6 = 12'h3E3
- ADD 4'b0001:
  - T4 = 12'h1A3
  - T5 = 12'h2E1 (n_CE=0, n_Lb=0)
  - T6 = 12'h3C7 (n_La=0, Eu)
- SUB 4'b0010: as ADD, except T6 = 12'h3CF (Su added).
- OUT 4'b1110:
  - T4 = 12'h3F2 (Ea, n_Lo=0)
  - T5 = T6 = 12'h3E3
- HLT 4'b1111:
  - On entering T4, hlt is set (registered on that falling edge) and the ring freezes at T4.
  - ctrl = 12'h3E3 while halted.
  - Only n_rst low clears the halted state.
- Any other opcode: NOP; T4..T6 = 12'h3E3.
- Opcode changes during T4..T6 take effect combinationally. The IR only loads in T3, so this does not occur in normal operation.
- Reset asserted mid-instruction (any state, including halted): immediate return to the reset values. The next instruction restarts at T1.
- Exactly one bit of t is high at all times. An illegal t value (SEU/X) recovers to T1 on the next falling edge.

Optional Feature:
- Macro: SAP1_SEQ_SKIP_IDLE_EN
- Defined: the ring returns to T1 on the falling edge after the last active state.
  - LDA: after T5 (5 states)
  - OUT: after T4 (4 states)
  - NOP: after T3 (3 states)
  - ADD/SUB: full 6 states
  - HLT: unchanged
- Undefined: every instruction takes exactly 6 states.

Test Plan:
- Reset/arm: hold n_rst=0 with clk toggling -> t=000001, ctrl=3E3, hlt=0. Release n_rst with clk high -> the following falling edge does not advance. After the next rising edge, the falling edge moves t to 000010.
- LDA fetch/execute: opcode=0000 -> ctrl sequence 5E3, BE3, 263, 1A3, 2C3, 3E3, then back to 5E3 at T1.
- ADD vs SUB: opcode=0001 gives T6 ctrl 3C7; opcode=0010 gives T6 ctrl 3CF. T4/T5 = 1A3/2E1 for both.
- OUT then HLT:
  - opcode=1110 -> T4 ctrl=3F2.
  - Next instruction opcode=1111 -> hlt=1 at T4, with t frozen at 001000 for 20 cycles.
  - n_rst pulse -> hlt=0, t=000001.
- Mid-instruction reset: assert n_rst=0 asynchronously at ADD T5 (between clock edges) -> ctrl becomes 3E3 and t becomes 000001 immediately, without waiting for a clock edge.
- SAP1_SEQ_SKIP_IDLE_EN defined: LDA, OUT, NOP, ADD back-to-back -> state counts 5, 4, 3, 6. Undefined: all 6.

Source files
------------

// File: rtl/sap1_control_sequencer.sv
// SAP-1 control sequencer: T1..T6 ring counter, opcode decode, halt latch.
// Optional macro SAP1_SEQ_SKIP_IDLE_EN ends each instruction after its last active state.
module sap1_control_sequencer (
  input  logic        clk,
  input  logic        n_rst,
  input  logic [3:0]  opcode,
  output logic [11:0] ctrl,
  output logic [5:0]  t,
  output logic        hlt
);

  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } ring_e;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  localparam logic [11:0] CW_IDLE = 12'h3E3;

  ring_e       ring_q, ring_d;
  ring_e       last;
  logic        hlt_q, hlt_d;
  logic        arm_q;
  logic [11:0] ctrl_w;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) arm_q <= 1'b0;
    else        arm_q <= 1'b1;
  end

  // Ring moves on the falling edge so ctrl is settled for every rising edge
  always_ff @(negedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ring_q <= T1;
      hlt_q  <= 1'b0;
    end else begin
      ring_q <= ring_d;
      hlt_q  <= hlt_d;
    end
  end

  always_comb begin
    last = T6;
`ifdef SAP1_SEQ_SKIP_IDLE_EN
    unique case (opcode)
      OP_LDA:         last = T5;
      OP_ADD, OP_SUB: last = T6;
      OP_OUT:         last = T4;
      OP_HLT:         last = T6;
      default:        last = T3;
    endcase
`endif
  end

  always_comb begin
    ring_d = ring_q;
    hlt_d  = hlt_q;
    if (!$onehot(ring_q)) begin
      ring_d = T1;
    end else if (arm_q && !hlt_q) begin
      if (ring_q == T3 && opcode == OP_HLT) begin
        ring_d = T4;
        hlt_d  = 1'b1;
      end else if (ring_q == last) begin
        ring_d = T1;
      end else begin
        ring_d = ring_e'({ring_q[4:0], ring_q[5]});
      end
    end
  end

  always_comb begin
    ctrl_w = CW_IDLE;
    if (!hlt_q) begin
      unique case (ring_q)
        T1: ctrl_w = 12'h5E3;
        T2: ctrl_w = 12'hBE3;
        T3: ctrl_w = 12'h263;
        T4: begin
          unique case (opcode)
            OP_LDA, OP_ADD, OP_SUB: ctrl_w = 12'h1A3;
            OP_OUT:                 ctrl_w = 12'h3F2;
            default:                ctrl_w = CW_IDLE;
          endcase
        end
        T5: begin
          unique case (opcode)
            OP_LDA:         ctrl_w = 12'h2C3;
            OP_ADD, OP_SUB: ctrl_w = 12'h2E1;
            default:        ctrl_w = CW_IDLE;
          endcase
        end
        T6: begin
          unique case (opcode)
            OP_ADD:  ctrl_w = 12'h3C7;
            OP_SUB:  ctrl_w = 12'h3CF;
            default: ctrl_w = CW_IDLE;
          endcase
        end
        default: ctrl_w = CW_IDLE;
      endcase
    end
  end

  // Reset must idle the bus at once, even though T1 is the reset state
  assign ctrl = n_rst ? ctrl_w : CW_IDLE;
  assign t    = ring_q;
  assign hlt  = hlt_q;

endmodule

// File: tb/tb_sap1_control_sequencer.sv
// Bench for sap1_control_sequencer: scoreboard of expected per-state outputs.
// Honours SAP1_SEQ_SKIP_IDLE_EN for expected instruction lengths.
module tb_sap1_control_sequencer;

  logic        clk;
  logic        n_rst;
  logic [3:0]  opcode;
  logic [11:0] ctrl;
  logic [5:0]  t;
  logic        hlt;

  int nvec = 0;
  int nerr = 0;

  typedef struct {
    logic [3:0]  op;
    logic [5:0]  t;
    logic [11:0] ctrl;
    logic        hlt;
  } exp_t;

  exp_t sb[$];

  sap1_control_sequencer dut (
    .clk    (clk),
    .n_rst  (n_rst),
    .opcode (opcode),
    .ctrl   (ctrl),
    .t      (t),
    .hlt    (hlt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  function automatic logic [5:0] ts(input int k);
    logic [5:0] one;
    one = 6'b000001;
    return one << (k - 1);
  endfunction

  function automatic void push(input logic [3:0] op, input int k,
                               input logic [11:0] cw, input logic h);
    exp_t e;
    e.op   = op;
    e.t    = ts(k);
    e.ctrl = cw;
    e.hlt  = h;
    sb.push_back(e);
  endfunction

  function automatic void push_instr(input logic [3:0] op);
    logic [11:0] ex [3];
    int          len;
    bit          skip;
`ifdef SAP1_SEQ_SKIP_IDLE_EN
    skip = 1'b1;
`else
    skip = 1'b0;
`endif
    push(op, 1, 12'h5E3, 1'b0);
    push(op, 2, 12'hBE3, 1'b0);
    push(op, 3, 12'h263, 1'b0);
    if (op == 4'b1111) begin
      for (int i = 0; i < 20; i++) push(op, 4, 12'h3E3, 1'b1);
      return;
    end
    ex[0] = 12'h3E3; ex[1] = 12'h3E3; ex[2] = 12'h3E3;
    len = 6;
    case (op)
      4'b0000: begin
        ex[0] = 12'h1A3; ex[1] = 12'h2C3;
        if (skip) len = 5;
      end
      4'b0001: begin
        ex[0] = 12'h1A3; ex[1] = 12'h2E1; ex[2] = 12'h3C7;
      end
      4'b0010: begin
        ex[0] = 12'h1A3; ex[1] = 12'h2E1; ex[2] = 12'h3CF;
      end
      4'b1110: begin
        ex[0] = 12'h3F2;
        if (skip) len = 4;
      end
      default: if (skip) len = 3;
    endcase
    for (int k = 4; k <= len; k++) push(op, k, ex[k-4], 1'b0);
  endfunction

  task automatic drain(input string tag);
    exp_t e;
    int   n;
    n = 0;
    while (sb.size() > 0) begin
      @(posedge clk); #1;
      e = sb.pop_front();
      if (e.t == 6'b000100) opcode = e.op;
      nvec++;
      if (t !== e.t) begin
        nerr++;
        $display("FAIL %s[%0d] t: got %b want %b", tag, n, t, e.t);
      end
      nvec++;
      if (ctrl !== e.ctrl) begin
        nerr++;
        $display("FAIL %s[%0d] ctrl: got %h want %h", tag, n, ctrl, e.ctrl);
      end
      nvec++;
      if (hlt !== e.hlt) begin
        nerr++;
        $display("FAIL %s[%0d] hlt: got %b want %b", tag, n, hlt, e.hlt);
      end
      n++;
    end
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 n_rst = 1'b1;
  endtask

  task automatic test_reset();
    n_rst  = 1'b0;
    opcode = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    nvec++;
    if (t !== 6'b000001) begin
      nerr++; $display("FAIL rst_t: got %b want 000001", t);
    end
    nvec++;
    if (ctrl !== 12'h3E3) begin
      nerr++; $display("FAIL rst_ctrl: got %h want 3e3", ctrl);
    end
    nvec++;
    if (hlt !== 1'b0) begin
      nerr++; $display("FAIL rst_hlt: got %b want 0", hlt);
    end
    n_rst = 1'b1;
    @(negedge clk); #1;
    nvec++;
    if (t !== 6'b000001) begin
      nerr++; $display("FAIL arm_hold_t: got %b want 000001", t);
    end
    nvec++;
    if (ctrl !== 12'h5E3) begin
      nerr++; $display("FAIL arm_hold_ctrl: got %h want 5e3", ctrl);
    end
    @(posedge clk); #1;
    nvec++;
    if (t !== 6'b000001) begin
      nerr++; $display("FAIL arm_edge_t: got %b want 000001", t);
    end
    @(negedge clk); #1;
    nvec++;
    if (t !== 6'b000010) begin
      nerr++; $display("FAIL arm_adv_t: got %b want 000010", t);
    end
    nvec++;
    if (ctrl !== 12'hBE3) begin
      nerr++; $display("FAIL arm_adv_ctrl: got %h want be3", ctrl);
    end
  endtask

  task automatic test_lda();
    do_reset();
    push_instr(4'b0000);
    push(4'b0000, 1, 12'h5E3, 1'b0);
    drain("lda");
  endtask

  task automatic test_add_sub();
    do_reset();
    push_instr(4'b0001);
    push_instr(4'b0010);
    drain("addsub");
  endtask

  task automatic test_out_hlt();
    do_reset();
    push_instr(4'b1110);
    push_instr(4'b1111);
    drain("outhlt");
    #2 n_rst = 1'b0;
    #1;
    nvec++;
    if (hlt !== 1'b0) begin
      nerr++; $display("FAIL hlt_clr: got %b want 0", hlt);
    end
    nvec++;
    if (t !== 6'b000001) begin
      nerr++; $display("FAIL hlt_clr_t: got %b want 000001", t);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    push_instr(4'b0001);
    for (int i = 0; i < 1; i++) void'(sb.pop_back());
    drain("mid");
    #2 n_rst = 1'b0;
    #1;
    nvec++;
    if (ctrl !== 12'h3E3) begin
      nerr++; $display("FAIL mid_rst_ctrl: got %h want 3e3", ctrl);
    end
    nvec++;
    if (t !== 6'b000001) begin
      nerr++; $display("FAIL mid_rst_t: got %b want 000001", t);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    push_instr(4'b0000);
    push_instr(4'b1110);
    push_instr(4'b0101);
    push_instr(4'b0001);
    push_instr(4'b0010);
    push_instr(4'b0000);
    push(4'b0000, 1, 12'h5E3, 1'b0);
    drain("b2b");
  endtask

  initial begin
    test_reset();
    test_lda();
    test_add_sub();
    test_out_hlt();
    test_mid_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
